// File: rtl/alu_pkg.sv
// alu_pkg: ALU function codes, legal-code check and arbiter state type shared by
// the alu_arbiter slice.
package alu_pkg;

  localparam logic [5:0] ALUFN_ADD   = 6'h00;
  localparam logic [5:0] ALUFN_SUB   = 6'h01;
  localparam logic [5:0] ALUFN_MUL   = 6'h02;
  localparam logic [5:0] ALUFN_XOR   = 6'h16;
  localparam logic [5:0] ALUFN_AND   = 6'h18;
  localparam logic [5:0] ALUFN_A     = 6'h1A;
  localparam logic [5:0] ALUFN_OR    = 6'h1E;
  localparam logic [5:0] ALUFN_SHL   = 6'h20;
  localparam logic [5:0] ALUFN_SHR   = 6'h21;
  localparam logic [5:0] ALUFN_SRA   = 6'h23;
  localparam logic [5:0] ALUFN_CMPEQ = 6'h33;
  localparam logic [5:0] ALUFN_CMPLT = 6'h35;
  localparam logic [5:0] ALUFN_CMPLE = 6'h37;

  // Any code outside this set is one the ALU does not implement.
  function automatic logic alu_fn_legal(input logic [5:0] fn);
    logic ok;
    ok = 1'b0;
    case (fn)
      ALUFN_ADD, ALUFN_SUB, ALUFN_MUL, ALUFN_XOR, ALUFN_AND, ALUFN_A, ALUFN_OR,
      ALUFN_SHL, ALUFN_SHR, ALUFN_SRA, ALUFN_CMPEQ, ALUFN_CMPLT, ALUFN_CMPLE: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin grant; 'last' is the index of the port served
// most recently and loses a tie. The pointer register lives in the caller.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned and infers a latch.
    grant = 2'b00;
    unique case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters, holding its
// inputs for SETTLE_CYCLES before capture. Optional macro: ALU_ARB_ILLEGAL_CHK_EN.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH         = 32,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [5:0]       req0_alufn,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [5:0]       req1_alufn,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_alu,
  output logic [2:0]       rsp0_flags,
  output logic             rsp0_err,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_alu,
  output logic [2:0]       rsp1_flags,
  output logic             rsp1_err,
  output logic [5:0]       alu_alufn,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_res,
  input  logic             alu_z,
  input  logic             alu_v,
  input  logic             alu_n,
  output logic             busy
);

  localparam int CNT_W = 4;

  arb_state_t       state, state_nxt;
  logic             last;
  logic             owner;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       grant;
  logic             accept;
  logic             capture;
  logic [5:0]       sel_alufn;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [WIDTH-1:0] res_q;
  logic [2:0]       flags_q;

  rr_arbiter2 u_rr (
    .req  ({req1_valid, req0_valid}),
    .last (last),
    .grant(grant)
  );

  assign sel_alufn = grant[1] ? req1_alufn : req0_alufn;
  assign sel_a     = grant[1] ? req1_a     : req0_a;
  assign sel_b     = grant[1] ? req1_b     : req0_b;

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    capture   = 1'b0;
    unique case (state)
      IDLE: begin
        if (|grant) begin
          accept    = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (cnt == '0) begin
          capture   = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (owner ? rsp1_ready : rsp0_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // ALU inputs only move at an accept edge, so the ALU never sees a glitch mid-settle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last      <= 1'b1;
      owner     <= 1'b0;
      cnt       <= '0;
      alu_alufn <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
    end else if (accept) begin
      owner     <= grant[1];
      last      <= grant[1];
      cnt       <= CNT_W'(SETTLE_CYCLES - 1);
      alu_alufn <= sel_alufn;
      alu_a     <= sel_a;
      alu_b     <= sel_b;
    end else if (state == ISSUE && cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

`ifdef ALU_ARB_ILLEGAL_CHK_EN
  logic ill_q;
  logic err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ill_q   <= 1'b0;
      res_q   <= '0;
      flags_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) ill_q <= !alu_fn_legal(sel_alufn);
      if (capture) begin
        res_q   <= ill_q ? '0 : alu_res;
        flags_q <= ill_q ? 3'b000 : {alu_z, alu_v, alu_n};
        err_q   <= ill_q;
      end
    end
  end

  assign rsp0_err = err_q;
  assign rsp1_err = err_q;
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q   <= '0;
      flags_q <= '0;
    end else if (capture) begin
      res_q   <= alu_res;
      flags_q <= {alu_z, alu_v, alu_n};
    end
  end

  assign rsp0_err = 1'b0;
  assign rsp1_err = 1'b0;
`endif

  // Ready is gated by rst_n so it drops the instant reset asserts, not at the next edge.
  assign req0_ready = rst_n & (state == IDLE) & grant[0];
  assign req1_ready = rst_n & (state == IDLE) & grant[1];

  assign rsp0_valid = (state == HOLD) & ~owner;
  assign rsp1_valid = (state == HOLD) &  owner;
  assign rsp0_alu   = res_q;
  assign rsp1_alu   = res_q;
  assign rsp0_flags = flags_q;
  assign rsp1_flags = flags_q;

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: two arbiter instances (settle 1 and 3) against a behavioural
// ALU and a transaction-level model; directed cases plus random traffic.
module tb_alu_arbiter;

  localparam int W  = 32;
  localparam int ND = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         req_valid [ND][2];
  logic         req_ready [ND][2];
  logic [5:0]   req_fn    [ND][2];
  logic [W-1:0] req_a     [ND][2];
  logic [W-1:0] req_b     [ND][2];
  logic         rsp_valid [ND][2];
  logic         rsp_ready [ND][2];
  logic [W-1:0] rsp_alu   [ND][2];
  logic [2:0]   rsp_flags [ND][2];
  logic         rsp_err   [ND][2];
  logic [5:0]   alu_fn    [ND];
  logic [W-1:0] alu_a     [ND];
  logic [W-1:0] alu_b     [ND];
  logic [W-1:0] alu_res   [ND];
  logic         alu_z     [ND];
  logic         alu_v     [ND];
  logic         alu_n     [ND];
  logic         busy      [ND];

  int n_tests = 0;
  int n_fail  = 0;
  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  logic [5:0] codes [15];

  function automatic int settle_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  // Reference ALU: flags come from the add/sub path selected by alufn[0].
  function automatic logic [W+2:0] alu_ref(input logic [5:0] fn, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    logic [W-1:0] s, r;
    logic v;
    s = fn[0] ? a - b : a + b;
    v = fn[0] ? ((a[W-1] != b[W-1]) && (s[W-1] != a[W-1]))
              : ((a[W-1] == b[W-1]) && (s[W-1] != a[W-1]));
    r = '0;
    case (fn)
      6'h00: r = a + b;
      6'h01: r = a - b;
      6'h02: r = a * b;
      6'h16: r = a ^ b;
      6'h18: r = a & b;
      6'h1A: r = a;
      6'h1E: r = a | b;
      6'h20: r = a << b[4:0];
      6'h21: r = a >> b[4:0];
      6'h23: r = $signed(a) >>> b[4:0];
      6'h33: r[0] = (a == b);
      6'h35: r[0] = ($signed(a) < $signed(b));
      6'h37: r[0] = ($signed(a) <= $signed(b));
      default: r = 32'hDEAD_BEEF;
    endcase
    return {r, s == '0, v, s[W-1]};
  endfunction

  function automatic logic is_legal_ref(input logic [5:0] fn);
    for (int i = 0; i < 13; i++) if (codes[i] == fn) return 1'b1;
    return 1'b0;
  endfunction

  // Expected response {result, flags, err} for an accepted request.
  function automatic logic [W+3:0] expect_rsp(input logic [5:0] fn, input logic [W-1:0] a,
                                              input logic [W-1:0] b);
`ifdef ALU_ARB_ILLEGAL_CHK_EN
    if (!is_legal_ref(fn)) return {{W{1'b0}}, 3'b000, 1'b1};
`endif
    return {alu_ref(fn, a, b), 1'b0};
  endfunction

  function automatic int winner(input logic v0, input logic v1, input logic last);
    if (v0 && v1) return last ? 0 : 1;
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  for (genvar d = 0; d < ND; d++) begin : g_dut
    localparam int S = (d == 0) ? 1 : 3;
    logic [W+2:0] alu_out;
    assign alu_out    = alu_ref(alu_fn[d], alu_a[d], alu_b[d]);
    assign alu_res[d] = alu_out[W+2:3];
    assign alu_z[d]   = alu_out[2];
    assign alu_v[d]   = alu_out[1];
    assign alu_n[d]   = alu_out[0];

    alu_arbiter #(.WIDTH(W), .SETTLE_CYCLES(S)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req0_valid(req_valid[d][0]),
      .req0_ready(req_ready[d][0]),
      .req0_alufn(req_fn[d][0]),
      .req0_a    (req_a[d][0]),
      .req0_b    (req_b[d][0]),
      .req1_valid(req_valid[d][1]),
      .req1_ready(req_ready[d][1]),
      .req1_alufn(req_fn[d][1]),
      .req1_a    (req_a[d][1]),
      .req1_b    (req_b[d][1]),
      .rsp0_valid(rsp_valid[d][0]),
      .rsp0_ready(rsp_ready[d][0]),
      .rsp0_alu  (rsp_alu[d][0]),
      .rsp0_flags(rsp_flags[d][0]),
      .rsp0_err  (rsp_err[d][0]),
      .rsp1_valid(rsp_valid[d][1]),
      .rsp1_ready(rsp_ready[d][1]),
      .rsp1_alu  (rsp_alu[d][1]),
      .rsp1_flags(rsp_flags[d][1]),
      .rsp1_err  (rsp_err[d][1]),
      .alu_alufn (alu_fn[d]),
      .alu_a     (alu_a[d]),
      .alu_b     (alu_b[d]),
      .alu_res   (alu_res[d]),
      .alu_z     (alu_z[d]),
      .alu_v     (alu_v[d]),
      .alu_n     (alu_n[d]),
      .busy      (busy[d])
    );
  end

  // Transaction-level model: one operation in flight, timestamped by cycle index.
  typedef struct {
    bit           busy;
    int           owner;
    bit           last;
    int           acc;
    int           cyc;
    logic [5:0]   fn;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W+3:0] rsp;
  } model_t;

  model_t mdl [ND];

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      for (int d = 0; d < ND; d++) begin
        int w;
        if (!rst_n) begin
          mdl[d].busy = 1'b0;
          mdl[d].owner = 0;
          mdl[d].last = 1'b1;
          mdl[d].acc = 0;
          mdl[d].cyc = 0;
          mdl[d].fn = '0;
          mdl[d].a = '0;
          mdl[d].b = '0;
          mdl[d].rsp = '0;
        end else begin
          if (mdl[d].busy) begin
            if (mdl[d].cyc >= mdl[d].acc + settle_of(d) && rsp_ready[d][mdl[d].owner])
              mdl[d].busy = 1'b0;
          end else begin
            w = winner(req_valid[d][0], req_valid[d][1], mdl[d].last);
            if (w >= 0) begin
              mdl[d].busy  = 1'b1;
              mdl[d].owner = w;
              mdl[d].last  = (w == 1);
              mdl[d].acc   = mdl[d].cyc + 1;
              mdl[d].fn    = req_fn[d][w];
              mdl[d].a     = req_a[d][w];
              mdl[d].b     = req_b[d][w];
              mdl[d].rsp   = expect_rsp(req_fn[d][w], req_a[d][w], req_b[d][w]);
            end
          end
          mdl[d].cyc = mdl[d].cyc + 1;
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Every-cycle comparison of all DUT outputs against the model, away from the rising edge.
  initial begin
    forever begin
      @(negedge clk);
      for (int d = 0; d < ND; d++) begin
        int  w;
        logic ev;
        w = (rst_n && !mdl[d].busy) ? winner(req_valid[d][0], req_valid[d][1], mdl[d].last) : -1;
        check($sformatf("d%0d busy", d), busy[d], mdl[d].busy);
        check($sformatf("d%0d alu_alufn", d), alu_fn[d], mdl[d].fn);
        check($sformatf("d%0d alu_a", d), alu_a[d], mdl[d].a);
        check($sformatf("d%0d alu_b", d), alu_b[d], mdl[d].b);
        for (int p = 0; p < 2; p++) begin
          ev = mdl[d].busy && mdl[d].owner == p && mdl[d].cyc >= mdl[d].acc + settle_of(d);
          check($sformatf("d%0d rsp%0d_valid", d, p), rsp_valid[d][p], ev);
          check($sformatf("d%0d req%0d_ready", d, p), req_ready[d][p], w == p);
          if (ev) begin
            check($sformatf("d%0d rsp%0d_alu", d, p), rsp_alu[d][p], mdl[d].rsp[W+3:4]);
            check($sformatf("d%0d rsp%0d_flags", d, p), rsp_flags[d][p], mdl[d].rsp[3:1]);
            check($sformatf("d%0d rsp%0d_err", d, p), rsp_err[d][p], mdl[d].rsp[0]);
          end
        end
      end
    end
  end

  task automatic drive_req(input int d, input int p, input logic [5:0] fn,
                           input logic [W-1:0] a, input logic [W-1:0] b);
    req_valid[d][p] = 1'b1;
    req_fn[d][p]    = fn;
    req_a[d][p]     = a;
    req_b[d][p]     = b;
  endtask

  // Returns which port was accepted and the index of the accepting edge.
  task automatic wait_accept(input int d, output int who, output int acc);
    who = -1;
    acc = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (req_ready[d][0]) who = 0;
      else if (req_ready[d][1]) who = 1;
      if (who >= 0) begin
        @(posedge clk);
        #1;
        acc = edge_cnt;
        req_valid[d][who] = 1'b0;
        return;
      end
    end
    timeout_fail($sformatf("d%0d accept", d));
  endtask

  task automatic wait_rsp(input int d, input int p, output int e, output logic [W-1:0] res,
                          output logic [2:0] fl, output logic err);
    e = 0; res = '0; fl = '0; err = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (rsp_valid[d][p]) begin
        e = edge_cnt; res = rsp_alu[d][p]; fl = rsp_flags[d][p]; err = rsp_err[d][p];
        return;
      end
    end
    timeout_fail($sformatf("d%0d rsp%0d", d, p));
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int who, acc, e, q;
    logic [W-1:0] res;
    logic [2:0] fl;
    logic err;
    bit took [ND][2];

    codes = '{6'h00, 6'h01, 6'h02, 6'h16, 6'h18, 6'h1A, 6'h1E, 6'h20, 6'h21, 6'h23,
              6'h33, 6'h35, 6'h37, 6'h3F, 6'h0C};
    for (int d = 0; d < ND; d++) begin
      for (int p = 0; p < 2; p++) begin
        req_valid[d][p] = 1'b0; req_fn[d][p] = '0; req_a[d][p] = '0; req_b[d][p] = '0;
        rsp_ready[d][p] = 1'b1; took[d][p] = 1'b0;
      end
    end

    // Reset state, with requests pending to show ready stays low.
    req_valid[0][0] = 1'b1;
    req_valid[1][1] = 1'b1;
    #7;
    check("reset req0_ready", req_ready[0][0], 1'b0);
    check("reset req1_ready", req_ready[1][1], 1'b0);
    check("reset busy", busy[0], 1'b0);
    check("reset rsp_alu", rsp_alu[0][0], 32'h0);
    check("reset alu_a", alu_a[1], 32'h0);
    req_valid[0][0] = 1'b0;
    req_valid[1][1] = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;

    // ADD 5 + 7 on port 0, one settle cycle.
    drive_req(0, 0, 6'h00, 32'd5, 32'd7);
    wait_accept(0, who, acc);
    check("add who", who, 0);
    wait_rsp(0, 0, e, res, fl, err);
    check("add latency", e - acc, 1);
    check("add result", res, 32'd12);
    check("add flags", fl, 3'b000);

    // Contention after reset: port 0 first, then port 1 beats a re-issued port 0.
    do_reset();
    drive_req(0, 0, 6'h01, 32'd3, 32'd3);
    drive_req(0, 1, 6'h02, 32'd6, 32'd7);
    wait_accept(0, who, acc);
    check("tie1 who", who, 0);
    drive_req(0, 0, 6'h01, 32'd3, 32'd3);
    wait_rsp(0, 0, e, res, fl, err);
    check("sub result", res, 32'd0);
    check("sub z flag", fl[2], 1'b1);
    wait_accept(0, who, acc);
    check("tie2 who", who, 1);
    check("back-to-back accept", acc - e, 2);
    wait_rsp(0, 1, e, res, fl, err);
    check("mul result", res, 32'd42);
    wait_accept(0, who, acc);
    check("tie3 who", who, 0);
    wait_rsp(0, 0, e, res, fl, err);

    // Backpressure on port 0 with port 1 waiting.
    @(posedge clk);
    #1 rsp_ready[0][0] = 1'b0;
    drive_req(0, 0, 6'h18, 32'h0000_F0F0, 32'h0000_FF00);
    wait_accept(0, who, acc);
    drive_req(0, 1, 6'h1E, 32'd1, 32'd2);
    wait_rsp(0, 0, e, res, fl, err);
    for (int i = 0; i < 4; i++) begin
      check("bp rsp0_valid", rsp_valid[0][0], 1'b1);
      check("bp rsp0_alu", rsp_alu[0][0], 32'h0000_F000);
      check("bp req1_ready", req_ready[0][1], 1'b0);
      @(negedge clk);
    end
    rsp_ready[0][0] = 1'b1;
    q = edge_cnt;
    wait_accept(0, who, acc);
    check("bp next who", who, 1);
    check("bp next accept edge", acc - q, 2);
    wait_rsp(0, 1, e, res, fl, err);
    check("or result", res, 32'd3);

    // CMPLT -1 < 1 with three settle cycles.
    drive_req(1, 1, 6'h35, 32'hFFFF_FFFF, 32'd1);
    wait_accept(1, who, acc);
    wait_rsp(1, 1, e, res, fl, err);
    check("cmplt latency", e - acc, 3);
    check("cmplt result", res, 32'd1);

    // Illegal function code.
    drive_req(0, 0, 6'h3F, 32'h1234, 32'h5678);
    wait_accept(0, who, acc);
    wait_rsp(0, 0, e, res, fl, err);
`ifdef ALU_ARB_ILLEGAL_CHK_EN
    check("illegal err", err, 1'b1);
    check("illegal result", res, 32'h0);
`else
    check("illegal err", err, 1'b0);
    check("illegal result", res, 32'hDEAD_BEEF);
`endif

    // Reset in ISSUE drops the operation; afterwards port 0 wins the first tie.
    @(posedge clk);
    #1;
    drive_req(1, 0, 6'h00, 32'd1, 32'd2);
    wait_accept(1, who, acc);
    drive_req(1, 1, 6'h00, 32'd100, 32'd1);
    drive_req(1, 0, 6'h00, 32'd10, 32'd20);
    #2 rst_n = 1'b0;
    #1;
    check("rst busy", busy[1], 1'b0);
    check("rst req0_ready", req_ready[1][0], 1'b0);
    check("rst req1_ready", req_ready[1][1], 1'b0);
    check("rst rsp0_valid", rsp_valid[1][0], 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    wait_accept(1, who, acc);
    check("post-rst who", who, 0);
    wait_rsp(1, 0, e, res, fl, err);
    check("post-rst result", res, 32'd30);
    wait_accept(1, who, acc);
    wait_rsp(1, 1, e, res, fl, err);
    check("post-rst port1 result", res, 32'd101);

    // Random traffic on both instances; valid held with stable operands until accepted.
    for (int cyc = 0; cyc < 320; cyc++) begin
      @(negedge clk);
      for (int d = 0; d < ND; d++)
        for (int p = 0; p < 2; p++) took[d][p] = req_valid[d][p] && req_ready[d][p];
      @(posedge clk);
      #1;
      for (int d = 0; d < ND; d++) begin
        for (int p = 0; p < 2; p++) begin
          if (took[d][p]) req_valid[d][p] = 1'b0;
          if (!req_valid[d][p] && cyc < 290 && $urandom_range(0, 2) == 0) begin
            drive_req(d, p, codes[$urandom_range(0, 14)],
                      $urandom_range(0, 1) ? W'($urandom) : W'($urandom_range(0, 8)),
                      $urandom_range(0, 1) ? W'($urandom) : W'($urandom_range(0, 8)));
          end
          rsp_ready[d][p] = (cyc >= 290) || ($urandom_range(0, 3) != 0);
        end
      end
    end
    for (int d = 0; d < ND; d++) check($sformatf("d%0d drained", d), busy[d], 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

- Shares the single combinational `Alu` instance between two requesters, e.g. the main pipeline and a secondary issue port.
- Arbitrates round-robin and registers operands onto the shared ALU inputs.
- Holds the operands for a programmable settle time, captures result and flags, then returns them over a per-requester valid/ready response port.
- Sits between the requesters and `Alu`; `Alu` itself is unchanged.

## Interface
Parameters:
- WIDTH, 32, operand/result width
- SETTLE_CYCLES, 1, cycles the ALU inputs are held before capture; legal 1..15

Ports (N = 0, 1; one set per requester):
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- reqN_valid  in  1  request valid
- reqN_ready  out  1  request accepted this cycle
- reqN_alufn  in  6  ALU function code
- reqN_a, reqN_b  in  WIDTH  operands
- rspN_valid  out  1  result valid
- rspN_ready  in  1  requester takes result
- rspN_alu  out  WIDTH  result
- rspN_flags  out  3  {z, v, n}
- rspN_err  out  1  illegal function code (see Configuration)
- alu_alufn  out  6  to ALU
- alu_a, alu_b  out  WIDTH  to ALU
- alu_res  in  WIDTH  from ALU
- alu_z, alu_v, alu_n  in  1  from ALU
- busy  out  1  state != IDLE

## Operation
States:
- IDLE: no operation in flight.
- ISSUE: ALU inputs driven, settle counter running.
- HOLD: result registered, waiting for the response handshake.

Arbitration in IDLE:
- `grantN` is combinational from `reqN_valid` and the round-robin pointer `last`.
- With a single valid requester, that requester wins.
- With both valid, the port other than `last` wins.
- `reqN_ready = (state == IDLE) & grantN`. Ready depends on valid; requesters must not make valid depend on ready.

Transitions:
- IDLE → ISSUE on the handshake. At that edge: `alu_alufn/a/b` ← the granted request; `owner` ← N; `last` ← N; counter ← SETTLE_CYCLES − 1.
- ISSUE: the counter decrements each cycle. When the counter reaches 0: `rsp_alu` ← `alu_res`, flags ← {`alu_z`, `alu_v`, `alu_n`}, state → HOLD.
- HOLD: `rsp{owner}_valid` = 1; the other response valid = 0. On `rsp{owner}_ready` → IDLE.
- `rspN_alu`, `rspN_flags` and `rspN_err` are both driven from one shared result register. Consumers qualify them with `rspN_valid` only.

ALU inputs:
- Hold their value in ISSUE, HOLD and IDLE. They change only at accept edges, so the ALU never sees glitching inputs.
- Flags are passed through unmodified; they are meaningful only for ADD/SUB codes.

## Timing
- Reset values: all `rspN_valid` = 0; `reqN_ready` = 0 until reset is released; `alu_alufn/a/b` = 0; `rspN_alu`, `rspN_flags`, `rspN_err` = 0; `busy` = 0; `last` = 1 (port 0 wins the first tie).
- Latency: request accepted at edge k → `rspN_valid` high after edge k + SETTLE_CYCLES.
- Throughput: with the response accepted at edge m, a new request can be accepted at edge m+1 (ready is high in the cycle after m). Minimum SETTLE_CYCLES + 2 cycles per operation.
- Backpressure: HOLD lasts indefinitely; the result stays stable and both `reqN_ready` stay 0.
- A request arriving during ISSUE/HOLD waits; its requester holds valid and operands stable.
- Reset mid-operation: the in-flight operation is dropped; no response is ever produced for it.

## Configuration
`ALU_ARB_ILLEGAL_CHK_EN`:
- Defined: at accept, the function code is checked against the legal set {0x00, 0x01, 0x02, 0x16, 0x18, 0x1A, 0x1E, 0x20, 0x21, 0x23, 0x33, 0x35, 0x37}.
- An illegal code still passes through ISSUE with the same latency, but captures `rsp_alu` = 0, flags = 0, `rsp_err` = 1.
- Undefined: no check; `rspN_err` is tied to 0 and the raw ALU output is returned.

## Structure
- Shared package `alu_pkg`:
  - localparams for every ALUFN code
  - the legal-code list/function used by the checker
  - the state enum `{IDLE, ISSUE, HOLD}`
- One sub-module `rr_arbiter2`: two request bits plus the `last` pointer in, one-hot grant out. The pointer register stays in `alu_arbiter`.

## Test plan
- Port 0 ADD, a = 5, b = 7, SETTLE_CYCLES = 1 → `rsp0_valid` one cycle after accept; `rsp0_alu` = 12, flags = 000; `rsp1_valid` stays 0.
- Both valid at once after reset:
  - port 0 SUB 3 − 3 → served first, `rsp0_alu` = 0, z = 1;
  - port 1 MUL 6 × 7 → served next, `rsp1_alu` = 42.
  - Repeat both: port 1 now served first.
- `rsp0_ready` held low 4 cycles with a pending `req1` → result and `rsp0_valid` stable, `req1_ready` = 0 throughout; `req1` accepted the cycle after the response handshake.
- SETTLE_CYCLES = 3, port 1 CMPLT a = 0xFFFFFFFF, b = 1 → `rsp1_valid` exactly 3 cycles after accept; `rsp1_alu` = 1.
- With `ALU_ARB_ILLEGAL_CHK_EN`: alufn = 0x3F → `rsp0_err` = 1, `rsp0_alu` = 0. Without it: `rsp0_err` = 0 and the ALU output is returned.
- `rst_n` asserted in ISSUE → all valids/readys 0 immediately, `busy` = 0; after release, simultaneous requests go to port 0 first.
